// File: rtl/decryption_sequencer.sv
// decryption_sequencer: frame-level controller for the decryptor datapath.
// Takes a header word (alg, len) followed by len payload words, steers the
// payload to one of three engines, owns the output mux select, and closes
// the frame by counting mux valids (or flags an error on bad header/timeout).
//
// Handshake: a word is transferred on a rising edge where valid_i=1 and
// busy_o=0; words offered while busy_o=1 are dropped. Engine valids and
// done_o/error_o are single-cycle pulses with no back-pressure.
module decryption_sequencer #(
   parameter int D_WIDTH   = 8,
   parameter int LEN_WIDTH = 6,
   parameter int TIMEOUT   = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [D_WIDTH-1:0] data_i,
   input  logic               valid_i,
   output logic               busy_o,
   output logic [D_WIDTH-1:0] data0_o,
   output logic [D_WIDTH-1:0] data1_o,
   output logic [D_WIDTH-1:0] data2_o,
   output logic               valid0_o,
   output logic               valid1_o,
   output logic               valid2_o,
   output logic [1:0]         select_o,
   input  logic               mux_valid_i,
   output logic               done_o,
   output logic               error_o
);

   localparam int TO_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TO_WIDTH-1:0]  TO_ONE  = TO_WIDTH'(1);
   localparam logic [TO_WIDTH-1:0]  TO_LAST = TO_WIDTH'(TIMEOUT - 1);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ROUTE   = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_DISCARD = 2'd3;

   logic [1:0]           state;
   logic [1:0]           alg_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] in_cnt;
   logic [LEN_WIDTH-1:0] out_cnt;
   logic [LEN_WIDTH-1:0] out_cnt_nxt;
   logic [TO_WIDTH-1:0]  to_cnt;
   logic [1:0]           hdr_alg;
   logic [LEN_WIDTH-1:0] hdr_len;

   assign hdr_alg = data_i[1:0];
   assign hdr_len = data_i[LEN_WIDTH+1:2];

   // Input is refused only while waiting for the mux to drain.
   assign busy_o = (state == S_DRAIN);

   // Mux valids are counted only while a routed frame is open, saturating at len_q.
   always_comb begin
      out_cnt_nxt = out_cnt;
      if ((state == S_ROUTE || state == S_DRAIN) && mux_valid_i && (out_cnt != len_q))
         out_cnt_nxt = out_cnt + LEN_ONE;
   end

   // Frame FSM, payload routing, and the done/error pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         alg_q    <= 2'd0;
         len_q    <= '0;
         in_cnt   <= '0;
         out_cnt  <= '0;
         to_cnt   <= '0;
         select_o <= 2'd0;
         data0_o  <= '0;
         data1_o  <= '0;
         data2_o  <= '0;
         valid0_o <= 1'b0;
         valid1_o <= 1'b0;
         valid2_o <= 1'b0;
         done_o   <= 1'b0;
         error_o  <= 1'b0;
      end else begin
         valid0_o <= 1'b0;
         valid1_o <= 1'b0;
         valid2_o <= 1'b0;
         done_o   <= 1'b0;
         error_o  <= 1'b0;
         out_cnt  <= out_cnt_nxt;
         case (state)
            S_IDLE: begin
               if (valid_i) begin
                  if (hdr_len == '0) begin
                     // Empty frame completes at once; select is left alone.
                     done_o <= 1'b1;
                  end else if (hdr_alg == 2'd3) begin
                     error_o <= 1'b1;
                     len_q   <= hdr_len;
                     in_cnt  <= '0;
                     state   <= S_DISCARD;
                  end else begin
                     alg_q    <= hdr_alg;
                     len_q    <= hdr_len;
                     select_o <= hdr_alg;
                     in_cnt   <= '0;
                     out_cnt  <= '0;
                     state    <= S_ROUTE;
                  end
               end
            end
            S_ROUTE: begin
               if (valid_i) begin
                  case (alg_q)
                     2'd0: begin
                        data0_o  <= data_i;
                        valid0_o <= 1'b1;
                     end
                     2'd1: begin
                        data1_o  <= data_i;
                        valid1_o <= 1'b1;
                     end
                     default: begin
                        data2_o  <= data_i;
                        valid2_o <= 1'b1;
                     end
                  endcase
                  in_cnt <= in_cnt + LEN_ONE;
                  if (in_cnt == len_q - LEN_ONE) begin
                     to_cnt <= '0;
                     state  <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (out_cnt_nxt == len_q) begin
                  done_o <= 1'b1;
                  state  <= S_IDLE;
               end else if (mux_valid_i) begin
                  // A valid on the expiry edge still rescues the frame.
                  to_cnt <= '0;
               end else if (to_cnt == TO_LAST) begin
                  error_o <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_ONE;
               end
            end
            default: begin
               // S_DISCARD: swallow the payload of a rejected frame.
               if (valid_i) begin
                  in_cnt <= in_cnt + LEN_ONE;
                  if (in_cnt == len_q - LEN_ONE)
                     state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decryption_sequencer.sv
// Directed bench for decryption_sequencer: inputs change 1 ns after each
// rising edge, outputs are checked right after that edge, and a negedge
// monitor matches every engine valid against an expected-word queue.
module tb_decryption_sequencer;

   logic       clk;
   logic       rst;
   logic [7:0] data_i;
   logic       valid_i;
   logic       busy_o;
   logic [7:0] data0_o;
   logic [7:0] data1_o;
   logic [7:0] data2_o;
   logic       valid0_o;
   logic       valid1_o;
   logic       valid2_o;
   logic [1:0] select_o;
   logic       mux_valid_i;
   logic       done_o;
   logic       error_o;

   int n_vec  = 0;
   int n_miss = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int d0;
   int e0;
   int k;
   bit seen;

   // {engine[1:0], data[7:0]} for every engine valid still expected
   logic [9:0] exp_q[$];

   decryption_sequencer #(
      .D_WIDTH(8),
      .LEN_WIDTH(6),
      .TIMEOUT(255)
   ) dut (
      .clk(clk),
      .rst(rst),
      .data_i(data_i),
      .valid_i(valid_i),
      .busy_o(busy_o),
      .data0_o(data0_o),
      .data1_o(data1_o),
      .data2_o(data2_o),
      .valid0_o(valid0_o),
      .valid1_o(valid1_o),
      .valid2_o(valid2_o),
      .select_o(select_o),
      .mux_valid_i(mux_valid_i),
      .done_o(done_o),
      .error_o(error_o)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pop_chk(input logic [1:0] eng, input logic [7:0] d);
      logic [9:0] e;
      if (exp_q.size() == 0) begin
         chk("unexpected_engine_valid", {22'd0, eng, d}, 32'h3ff);
      end else begin
         e = exp_q.pop_front();
         chk("engine_word", {22'd0, eng, d}, {22'd0, e});
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (done_o) done_cnt++;
         if (error_o) err_cnt++;
         if (valid0_o) pop_chk(2'd0, data0_o);
         if (valid1_o) pop_chk(2'd1, data1_o);
         if (valid2_o) pop_chk(2'd2, data2_o);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      valid_i = 1'b1;
      data_i  = d;
      cyc();
      valid_i = 1'b0;
   endtask

   task automatic expect_word(input logic [1:0] eng, input logic [7:0] d);
      exp_q.push_back({eng, d});
   endtask

   initial begin
      rst = 1'b1;
      data_i = 8'h00;
      valid_i = 1'b0;
      mux_valid_i = 1'b0;
      repeat (3) cyc();
      rst = 1'b0;
      cyc();

      // reset values
      chk("rst_busy", busy_o, 0);
      chk("rst_select", select_o, 0);
      chk("rst_data", {data0_o, data1_o, data2_o}, 0);
      chk("rst_valid", {valid0_o, valid1_o, valid2_o}, 0);
      chk("rst_done_err", {done_o, error_o}, 0);

      // caesar frame: 0x0C = alg 0, len 3
      d0 = done_cnt;
      send(8'h0C);
      chk("c_select", select_o, 0);
      chk("c_busy_hdr", busy_o, 0);
      expect_word(2'd0, 8'h41);
      expect_word(2'd0, 8'h42);
      expect_word(2'd0, 8'h43);
      send(8'h41);
      chk("c_valid0", valid0_o, 1);
      send(8'h42);
      send(8'h43);
      chk("c_busy_drain", busy_o, 1);
      cyc();
      cyc();
      chk("c_busy_wait", busy_o, 1);
      mux_valid_i = 1'b1;
      cyc();
      cyc();
      chk("c_no_done_early", done_o, 0);
      cyc();
      mux_valid_i = 1'b0;
      chk("c_done", done_o, 1);
      chk("c_idle_busy", busy_o, 0);
      cyc();
      chk("c_done_one_cycle", done_o, 0);
      chk("c_done_count", done_cnt - d0, 1);
      chk("c_data0_hold", data0_o, 8'h43);

      // zigzag 0x0A (alg 2, len 2), mux valids on both payload edges
      d0 = done_cnt;
      send(8'h0A);
      chk("z_select", select_o, 2);
      expect_word(2'd2, 8'h11);
      expect_word(2'd2, 8'h22);
      mux_valid_i = 1'b1;
      send(8'h11);
      send(8'h22);
      mux_valid_i = 1'b0;
      chk("z_busy", busy_o, 1);
      cyc();
      chk("z_done_on_entry", done_o, 1);
      // next header in the cycle done is high: 0x05 = alg 1, len 1
      send(8'h05);
      chk("s_select", select_o, 1);
      chk("s_done_low", done_o, 0);
      expect_word(2'd1, 8'h33);
      send(8'h33);
      mux_valid_i = 1'b1;
      cyc();
      mux_valid_i = 1'b0;
      chk("s_done", done_o, 1);
      cyc();
      chk("z_done_count", done_cnt - d0, 2);

      // invalid algorithm 0x0B (alg 3, len 2)
      e0 = err_cnt;
      send(8'h0B);
      chk("inv_error", error_o, 1);
      chk("inv_select", select_o, 1);
      send(8'hAA);
      chk("inv_error_one_cycle", error_o, 0);
      send(8'hBB);
      chk("inv_err_count", err_cnt - e0, 1);
      // zero length header 0x02 (alg 2, len 0): proves IDLE, select unchanged
      send(8'h02);
      chk("zl_done", done_o, 1);
      chk("zl_select", select_o, 1);
      chk("zl_busy", busy_o, 0);

      // busy drop: 0x04 (alg 0, len 1), word offered during DRAIN
      send(8'h04);
      expect_word(2'd0, 8'h55);
      send(8'h55);
      valid_i = 1'b1;
      data_i  = 8'h99;
      cyc();
      chk("bd_busy", busy_o, 1);
      chk("bd_no_fwd", valid0_o, 0);
      cyc();
      valid_i = 1'b0;
      mux_valid_i = 1'b1;
      cyc();
      mux_valid_i = 1'b0;
      chk("bd_done", done_o, 1);
      chk("bd_data0", data0_o, 8'h55);
      cyc();

      // drain timeout: 0x08 (alg 0, len 2), only one mux valid
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'h08);
      expect_word(2'd0, 8'h61);
      expect_word(2'd0, 8'h62);
      send(8'h61);
      send(8'h62);
      mux_valid_i = 1'b1;
      cyc();
      mux_valid_i = 1'b0;
      k = 0;
      seen = 1'b0;
      for (int i = 1; i <= 400 && !seen; i++) begin
         cyc();
         if (error_o) begin
            k = i;
            seen = 1'b1;
         end
      end
      chk("to_latency", k, 255);
      chk("to_busy", busy_o, 0);
      cyc();
      chk("to_err_one_cycle", error_o, 0);
      chk("to_no_done", done_cnt - d0, 0);
      chk("to_err_count", err_cnt - e0, 1);

      // async reset mid-ROUTE: 0x0D (alg 1, len 3)
      send(8'h0D);
      expect_word(2'd1, 8'h71);
      send(8'h71);
      #7;
      rst = 1'b1;
      #1;
      chk("ar_select", select_o, 0);
      chk("ar_data1", data1_o, 0);
      chk("ar_busy", busy_o, 0);
      chk("ar_valid_done_err", {valid0_o, valid1_o, valid2_o, done_o, error_o}, 0);
      rst = 1'b0;
      cyc();
      send(8'h04);
      expect_word(2'd0, 8'h7E);
      send(8'h7E);
      mux_valid_i = 1'b1;
      cyc();
      mux_valid_i = 1'b0;
      chk("ar_done_after", done_o, 1);
      chk("ar_select_after", select_o, 0);
      cyc();
      cyc();

      chk("exp_q_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/decryption_sequencer.md
# decryption_sequencer

Frame-level controller for the decryptor datapath. It accepts a byte stream in which each frame is one header word followed by N payload words. It routes the payload to one of the three decryption engines (0 caesar, 1 scytale, 2 zigzag) and drives the output mux `select_o`. It then counts the mux's valid outputs to close the frame. It sits between the input interface and the engines/mux, and is the only block that changes the mux select.

## Interface
- `D_WIDTH`, 8, data word width; must be ≥ `LEN_WIDTH`+2
- `LEN_WIDTH`, 6, header length field width (max frame length 2^`LEN_WIDTH`−1)
- `TIMEOUT`, 255, max idle cycles in DRAIN waiting for a mux valid
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `data_i` in `D_WIDTH`: input stream word
- `valid_i` in 1: `data_i` valid
- `busy_o` out 1: 1 = input not accepted this cycle
- `data0_o`/`data1_o`/`data2_o` out `D_WIDTH` each: payload to caesar/scytale/zigzag
- `valid0_o`/`valid1_o`/`valid2_o` out 1 each: payload valid per engine
- `select_o` out 2: mux select
- `mux_valid_i` in 1: mux output valid (monitor only)
- `done_o` out 1: one-cycle pulse, frame complete
- `error_o` out 1: one-cycle pulse, bad header or drain timeout

## Operation
- Header word fields:
  - alg = `data_i[1:0]`
  - len = `data_i[LEN_WIDTH+1:2]`
- Registers: alg_q, len_q, in_cnt, out_cnt, to_cnt (width ≥ clog2(`TIMEOUT`+1)).
- States: IDLE, ROUTE, DRAIN, DISCARD.
- **IDLE** (`busy_o`=0): `valid_i` is taken as a header.
  - len=0: `done_o` pulses next cycle, stay IDLE, `select_o` unchanged.
  - alg=3, len>0: `error_o` pulses, go DISCARD.
  - Otherwise: alg_q←alg, len_q←len, `select_o`←alg, in_cnt←0, out_cnt←0, go ROUTE.
- **ROUTE** (`busy_o`=0): each `valid_i` word is forwarded registered to engine alg_q.
  - data{alg_q}_o←`data_i`, valid{alg_q}_o←1; the other two valids stay 0.
  - in_cnt increments per word.
  - On the word where in_cnt = len_q−1: go DRAIN, to_cnt←0.
- **DRAIN** (`busy_o`=1): wait for the remaining mux outputs.
  - When out_cnt reaches len_q: `done_o` pulse, go IDLE.
  - to_cnt increments each cycle without `mux_valid_i` and resets to 0 on `mux_valid_i`.
  - When to_cnt = `TIMEOUT`: `error_o` pulse, go IDLE.
- **DISCARD** (`busy_o`=0): consume and drop len `valid_i` words (no engine valid), then go IDLE.
- out_cnt increments on `mux_valid_i` in ROUTE and DRAIN and saturates at len_q. `mux_valid_i` in IDLE/DISCARD is ignored.
- `valid_i` while `busy_o`=1 is dropped; the sender must honour `busy_o`.
- `select_o` holds its last value in IDLE until the next accepted valid header.
- Engine data outputs hold their last value; only valids are pulses.

## Timing
- Reset values: state=IDLE, `busy_o`=0, `select_o`=0, all data*_o=0, all valid*_o=0, `done_o`=0, `error_o`=0, all counters 0.
- Reset mid-frame: abort immediately to reset values, no `done_o`/`error_o`.
- Latencies:
  - Header accepted at edge k: `select_o` valid after edge k.
  - First payload accepted at edge k+1 or later.
  - Payload accepted at edge m appears on the engine port after edge m, for one cycle.
  - `busy_o` rises in the cycle after the last payload edge.
- `done_o`/`error_o` assert for exactly one cycle, in the cycle after the deciding edge. State is IDLE in that same cycle, so a new header is accepted immediately.
- Last payload word and `mux_valid_i` on the same edge: both counted.
- If out_cnt already equals len_q on DRAIN entry, `done_o` pulses on the first DRAIN cycle.
- `mux_valid_i` and timeout expiry on the same edge: the valid wins, to_cnt resets.
- Gaps (`valid_i`=0) inside ROUTE/DISCARD are allowed indefinitely; there is no timeout there.

## Test plan
- Caesar frame:
  - Stimulus: header 0x0C (alg 0, len 3), payload 0x41, 0x42, 0x43; mux returns 3 valids 2 cycles later.
  - Response: `valid0_o` pulses 3× with 0x41..0x43, `select_o`=0, `busy_o` high during DRAIN, one `done_o`.
- Zigzag, back-to-back frames:
  - Stimulus: header 0x0A (alg 2, len 2), 2 words, then header 0x05 (alg 1, len 1) sent the cycle `done_o` is high.
  - Response: `select_o` 2 then 1, two `done_o` pulses.
- Invalid algorithm:
  - Stimulus: header 0x0B (alg 3, len 2) plus 2 words.
  - Response: `error_o` pulse, no engine valid, `select_o` unchanged, IDLE after 2nd word.
- Zero length and busy drop:
  - Stimulus: header 0x01 (len 0), then `valid_i` driven during DRAIN of a len-1 frame.
  - Response: `done_o` the next cycle; the word sent during DRAIN is dropped, not forwarded.
- Drain timeout:
  - Stimulus: len 2 frame, mux returns only 1 valid.
  - Response: `error_o` exactly `TIMEOUT` cycles after the last `mux_valid_i`, no `done_o`, back to IDLE.
- Async reset:
  - Stimulus: assert `rst` mid-ROUTE, between clock edges.
  - Response: all outputs at reset values immediately; after release a new frame completes normally.
